// File: rtl/demux_pkg.sv
// Shared types for the 1-to-2 stream demux.
// Destination codes and routing FSM states.
package demux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic DEST_OUT0 = 1'b0;
  localparam logic DEST_OUT1 = 1'b1;

endpackage

// File: rtl/demux_out_slice.sv
// One-entry output register slot.
// Refill is allowed in the same cycle as a drain.
module demux_out_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_last,
  input  logic             rd_ready,
  output logic             full,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last,
  output logic             can_accept
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  assign can_accept = ~full_q | rd_ready;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    last_d = last_q;
    if (wr_en) begin
      full_d = 1'b1;
      data_d = wr_data;
      last_d = wr_last;
    end else if (full_q && rd_ready) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  assign full    = full_q;
  assign rd_data = data_q;
  assign rd_last = last_q;

endmodule

// File: rtl/demux_1_to_2_stream.sv
// Packet-locked 1-to-2 stream demux.
// in_sel is latched on a packet's first beat.
module demux_1_to_2_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic             busy
);

  state_e state_q, state_d;
  logic   lock_sel_q, lock_sel_d;
  logic   dest;
  logic   accept;
  logic   can0, can1;
  logic   wr0, wr1;

  assign dest = (state_q == IDLE) ? in_sel : lock_sel_q;

  assign in_ready = (dest == DEST_OUT1) ? can1 : can0;
  assign accept   = in_valid & in_ready;
  assign wr0      = accept & (dest == DEST_OUT0);
  assign wr1      = accept & (dest == DEST_OUT1);

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !in_last) begin
          state_d    = LOCKED;
          lock_sel_d = in_sel;
        end
      end
      LOCKED: begin
        if (accept && in_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  assign busy = (state_q == LOCKED);

  demux_out_slice #(.WIDTH(WIDTH)) u_slice0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr0),
    .wr_data    (in_data),
    .wr_last    (in_last),
    .rd_ready   (out0_ready),
    .full       (out0_valid),
    .rd_data    (out0_data),
    .rd_last    (out0_last),
    .can_accept (can0)
  );

  demux_out_slice #(.WIDTH(WIDTH)) u_slice1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr1),
    .wr_data    (in_data),
    .wr_last    (in_last),
    .rd_ready   (out1_ready),
    .full       (out1_valid),
    .rd_data    (out1_data),
    .rd_last    (out1_last),
    .can_accept (can1)
  );

endmodule
